// File: rtl/read_requester_if.sv
// Read-requester bundle: burst command/status toward the controller plus the rd/ack/rd_data
// handshake toward the slave. The requester holds the master modport.
interface read_requester_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              ack;
  logic              rd_data;
  logic              rd;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  count;
  logic              timeout_err;

  modport master (
    input  start, len, ack, rd_data,
    output rd, busy, done, data, count, timeout_err
  );

  modport slave (
    output start, len, ack, rd_data,
    input  rd, busy, done, data, count, timeout_err
  );
endinterface

// File: rtl/read_requester.sv
// Burst read master for a rd/ack single-bit slave. Each read raises rd until ack, then releases
// rd for one clock. Bits are packed MSB-first; done pulses at the end; a timeout sets a sticky error.
module read_requester #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 8,
  parameter int TMR_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  read_requester_if.master   bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_FIN, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    data_d  = data_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          data_d  = '0;
          count_d = '0;
          timer_d = '0;
          err_d   = 1'b0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        if (bus.ack) begin
          data_d  = {data_q[DATA_W-2:0], bus.rd_data};
          count_d = count_q + 1'b1;
          timer_d = '0;
          state_d = S_REL;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // rd is low here for one clock so the slave can drop back to its idle state
      S_REL:   state_d = (count_q == len_q) ? S_FIN : S_REQ;
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state register directly, so reset drops rd without a clock edge
  assign bus.rd          = (state_q == S_REQ);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FIN) || (state_q == S_ERR);
  assign bus.data        = data_q;
  assign bus.count       = count_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_read_requester.sv
// Directed bench for read_requester driven against a behavioural IDLE/READ/ACK_NOW slave.
module tb_read_requester;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_requester_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  read_requester #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(8), .TMR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Slave: IDLE -rd-> READ -> ACK_NOW (ack high) -!rd-> IDLE
  typedef enum logic [1:0] {SL_IDLE, SL_READ, SL_ACK} sl_t;
  sl_t         sl_q;
  int          s_cnt;
  int          s_base;
  int          off;
  logic        ack_en;
  logic [15:0] cur_bits;
  int          cur_len;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sl_q  <= SL_IDLE;
      s_cnt <= 0;
    end else begin
      case (sl_q)
        SL_IDLE: if (bus.rd) sl_q <= SL_READ;
        SL_READ: sl_q <= SL_ACK;
        SL_ACK:  if (!bus.rd) begin
          sl_q  <= SL_IDLE;
          s_cnt <= s_cnt + 1;
        end
        default: sl_q <= SL_IDLE;
      endcase
    end
  end

  always_comb begin
    off         = s_cnt - s_base;
    bus.ack     = (sl_q == SL_ACK) && ack_en;
    bus.rd_data = 1'b0;
    if (bus.ack && off >= 0 && off < cur_len)
      bus.rd_data = cur_bits[cur_len-1-off];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One burst; bits are written first-read-first (MSB of the len-bit field is read first).
  // inject_at >= 0 pulses start with len=2 at that cycle to exercise start-while-busy.
  task automatic run_burst(input int len, input logic [15:0] bits, input logic aen,
                           input int inject_at,
                           output int done_n, output int rd_hi, output int pulses);
    int   n;
    logic prev_rd;
    @(negedge clk);
    cur_bits  = bits;
    cur_len   = len;
    ack_en    = aen;
    s_base    = s_cnt;
    bus.len   = CNT_W'(len);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0; rd_hi = 0; pulses = 0; prev_rd = 1'b0;
    while (!bus.done && n < 200) begin
      if (bus.rd) rd_hi++;
      if (bus.rd && !prev_rd) pulses++;
      prev_rd = bus.rd;
      if (n == inject_at) begin
        bus.len   = 4'd2;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    done_n = (n >= 200) ? -1 : n;
  endtask

  typedef struct {
    int          len;
    logic [15:0] bits;
    logic        ack_en;
    logic [7:0]  exp_data;
    int          exp_count;
    logic        exp_err;
    int          exp_done;
    int          exp_rd_hi;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dn, rh, pl;

    vecs[0] = '{1,  16'b1,              1'b1, 8'h01, 1,  1'b0, 4,  3,  1};
    vecs[1] = '{8,  16'b10110010,       1'b1, 8'hB2, 8,  1'b0, 32, 24, 8};
    vecs[2] = '{12, 16'b111101011010,   1'b1, 8'h5A, 12, 1'b0, 48, 36, 12};
    vecs[3] = '{0,  16'b0,              1'b1, 8'h00, 0,  1'b0, 0,  0,  0};
    vecs[4] = '{3,  16'b111,            1'b0, 8'h00, 0,  1'b1, 8,  8,  1};
    vecs[5] = '{2,  16'b11,             1'b1, 8'h03, 2,  1'b0, 8,  6,  2};

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    ack_en    = 1'b1;
    cur_bits  = '0;
    cur_len   = 0;
    s_base    = 0;
    #1;
    check("reset_rd",    32'(bus.rd),          0);
    check("reset_busy",  32'(bus.busy),        0);
    check("reset_done",  32'(bus.done),        0);
    check("reset_data",  32'(bus.data),        0);
    check("reset_count", 32'(bus.count),       0);
    check("reset_err",   32'(bus.timeout_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i].len, vecs[i].bits, vecs[i].ack_en, -1, dn, rh, pl);
      check($sformatf("v%0d_done_cycle", i), 32'(dn),  32'(vecs[i].exp_done));
      check($sformatf("v%0d_rd_cycles", i),  32'(rh),  32'(vecs[i].exp_rd_hi));
      check($sformatf("v%0d_rd_pulses", i),  32'(pl),  32'(vecs[i].exp_pulses));
      check($sformatf("v%0d_data", i),       32'(bus.data),        32'(vecs[i].exp_data));
      check($sformatf("v%0d_count", i),      32'(bus.count),       32'(vecs[i].exp_count));
      check($sformatf("v%0d_err", i),        32'(bus.timeout_err), 32'(vecs[i].exp_err));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_1cyc", i),  32'(bus.done), 0);
      check($sformatf("v%0d_idle", i),       32'(bus.busy), 0);
      repeat (2) @(posedge clk); #1;
      check($sformatf("v%0d_err_held", i),   32'(bus.timeout_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_data_held", i),  32'(bus.data),        32'(vecs[i].exp_data));
      check($sformatf("v%0d_count_held", i), 32'(bus.count),       32'(vecs[i].exp_count));
    end

    // start with len=2 pulsed during a len=5 burst must be ignored
    run_burst(5, 16'b10011, 1'b1, 6, dn, rh, pl);
    check("busy_start_done_cycle", 32'(dn),        20);
    check("busy_start_count",      32'(bus.count), 5);
    check("busy_start_data",       32'(bus.data),  32'h13);
    check("busy_start_pulses",     32'(pl),        5);
    repeat (3) @(posedge clk); #1;
    check("busy_start_no_requeue", 32'(bus.busy),  0);

    // asynchronous reset during the third read of a len=6 burst
    @(negedge clk);
    cur_bits  = 16'b101010;
    cur_len   = 6;
    ack_en    = 1'b1;
    s_base    = s_cnt;
    bus.len   = 4'd6;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_rst_pre_rd",    32'(bus.rd),    1);
    check("mid_rst_pre_count", 32'(bus.count), 2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rd",    32'(bus.rd),    0);
    check("mid_rst_busy",  32'(bus.busy),  0);
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_data",  32'(bus.data),  0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_burst(2, 16'b01, 1'b1, -1, dn, rh, pl);
    check("post_rst_done_cycle", 32'(dn),        8);
    check("post_rst_count",      32'(bus.count), 2);
    check("post_rst_data",       32'(bus.data),  32'h01);
    check("post_rst_err",        32'(bus.timeout_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/read_requester.md
Name: read_requester

Overview:
Upstream master for the rd/ack read-handshake state machine (IDLE/READ/ACK_NOW). On a start command it issues a burst of single-bit read transactions. Each transaction raises rd, waits for ack, captures rd_data, then releases rd so the slave can return to IDLE. Collected bits are assembled MSB-first into a parallel word, with a done pulse and a timeout error flag.

Parameters:
DATA_W, 8, width of assembled data word
CNT_W, 4, width of len and count; a burst is at most 2^CNT_W-1 reads
TIMEOUT, 8, max clocks spent in REQ waiting for ack before error (>=4)
TMR_W, 4, width of the wait timer; must hold TIMEOUT-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle burst request; sampled only in IDLE
len  input  CNT_W  number of reads in the burst; latched with start
ack  input  1  acknowledge from slave state machine
rd_data  input  1  read bit from slave; valid while ack=1
rd  output  1  read request to slave
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of burst (normal or error)
data  output  DATA_W  assembled read data, MSB = first bit read
count  output  CNT_W  reads completed in the current or last burst
timeout_err  output  1  sticky error; cleared on next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE; rd=0, busy=0, done=0, data=0, count=0, timeout_err=0, timer=0, latched len=0.
- All outputs are registered. rd=1 only in REQ. done=1 only in FIN or ERR.
- IDLE, start=1, len!=0: latch len, clear data/count/timer/timeout_err, go to REQ.
- IDLE, start=1, len==0: clear data/count/timeout_err, go to FIN. No rd is issued.
- REQ, ack=1 at the edge: data <= {data[DATA_W-2:0], rd_data}, count+1, timer=0, go to REL.
- REQ, ack=0, timer==TIMEOUT-1: go to ERR. Otherwise timer+1 and stay in REQ.
- REL: rd=0 for exactly one clock, so the slave leaves ACK_NOW for IDLE. ack is ignored here.
  - count==latched len: go to FIN.
  - otherwise: go to REQ.
- FIN: done=1 for one clock, then IDLE.
- ERR: done=1 and timeout_err=1 for one clock, then IDLE. timeout_err stays 1 in IDLE.
- Timing with the slave: REQ lasts 3 clocks (slave IDLE->READ->ACK_NOW, ack sampled on the 3rd edge), then REL lasts 1 clock. Each read therefore takes 4 clocks, and done is high in the clock starting 4*len edges after the edge that sampled start.
- Burst longer than DATA_W: data keeps the last DATA_W bits; count continues to len.
- count, data and timeout_err hold their values in IDLE until the next accepted start.
- start while busy: ignored, no queuing. len is only sampled with an accepted start.
- Reset mid-burst: rd drops immediately (async) and all registers return to reset values. The slave is reset by the same rst.

Test Plan:
- With the slave model: len=1, rd_data=1 -> rd high for 3 clocks; done 4 clocks after start; data=8'h01, count=1, timeout_err=0.
- len=8, slave returns bits 1,0,1,1,0,0,1,0 -> 8 rd pulses of 3 clocks separated by 1-clock gaps; done at clock 32; data=8'hB2, count=8.
- len=0 -> no rd; done one clock after start; count=0, data=0.
- ack tied 0, len=3 -> rd high 8 clocks then low; done pulse; timeout_err=1 held in IDLE; next start with working slave clears it.
- start pulsed again mid-burst with len=2 while running len=5 -> ignored; count ends at 5.
- rst=0 during the 3rd read of len=6 -> rd, busy and count go to 0 without waiting for a clock edge; after release a new len=2 burst completes normally with count=2.
